add_nibble_seq_ctrl: RTL

//  Sequencer that performs a WIDTH-bit add on one shared 4-bit ripple adder, one nibble per clock.

---
 rtl/add_nibble_seq_ctrl.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/add_nibble_seq_ctrl.sv
// Multi-cycle WIDTH-bit adder sequencing one shared 4-bit adder, one nibble per clock.
// Optional ADD_SEQ_OVF_EN adds a registered signed-overflow output (ovf).
module add_nibble_seq_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
`ifdef ADD_SEQ_OVF_EN
    output logic             ovf,
`endif
    output logic [3:0]       adder_a,
    output logic [3:0]       adder_b,
    output logic             adder_cin,
    input  logic [3:0]       adder_s,
    input  logic             adder_cout
);

    localparam int NIB = WIDTH / 4;
    localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IW-1:0] LAST = IW'(NIB - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_partial;
    logic [WIDTH-1:0] r_sum;
    logic [IW-1:0]    r_idx;
    logic             r_carry;
    logic             r_cout;
    logic             r_ready;
    logic             r_busy;
    logic             r_done;
`ifdef ADD_SEQ_OVF_EN
    logic             r_ovf;
`endif

    logic [WIDTH-1:0] w_sum_next;
    logic             w_run;
    logic             w_last;

    assign w_run  = (r_state == RUN);
    assign w_last = (r_idx == LAST);

    // Operand nibbles come only from registers; adder_s never reaches an output.
    assign adder_a   = w_run ? r_a[{r_idx, 2'b00} +: 4] : 4'h0;
    assign adder_b   = w_run ? r_b[{r_idx, 2'b00} +: 4] : 4'h0;
    assign adder_cin = w_run ? r_carry : 1'b0;

    always_comb begin
        w_sum_next = r_partial;
        w_sum_next[{r_idx, 2'b00} +: 4] = adder_s;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_a       <= '0;
            r_b       <= '0;
            r_partial <= '0;
            r_sum     <= '0;
            r_idx     <= '0;
            r_carry   <= 1'b0;
            r_cout    <= 1'b0;
            r_ready   <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
`ifdef ADD_SEQ_OVF_EN
            r_ovf     <= 1'b0;
`endif
        end else begin
            unique case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (start && r_ready) begin
                        r_a       <= a;
                        r_b       <= b;
                        r_carry   <= c_in;
                        r_idx     <= '0;
                        r_partial <= '0;
                        r_ready   <= 1'b0;
                        r_busy    <= 1'b1;
                        r_state   <= RUN;
                    end
                end
                RUN: begin
                    r_partial <= w_sum_next;
                    r_carry   <= adder_cout;
                    r_idx     <= r_idx + 1'b1;
                    if (w_last) begin
                        r_sum   <= w_sum_next;
                        r_cout  <= adder_cout;
                        r_done  <= 1'b1;
                        r_state <= DONE;
`ifdef ADD_SEQ_OVF_EN
                        r_ovf   <= r_a[WIDTH-1] ^ r_b[WIDTH-1]
                                 ^ adder_s[3] ^ adder_cout;
`endif
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_ready <= 1'b1;
                    r_state <= IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_ready <= 1'b1;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign ready = r_ready;
    assign busy  = r_busy;
    assign done  = r_done;
    assign sum   = r_sum;
    assign c_out = r_cout;
`ifdef ADD_SEQ_OVF_EN
    assign ovf   = r_ovf;
`endif

endmodule
